// File: rtl/uart_bus_pkg.sv
// Shared constants and state encodings for the UART bus master.
package uart_bus_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [7:0] RSP_TO  = 8'h54;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR,
    P_DATA,
    P_BUS,
    P_REPLY
  } pstate_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxstate_t;

  typedef enum logic [1:0] {
    RP_OK,
    RP_ERR,
    RP_TO,
    RP_RD
  } rkind_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter; a start issued during the done cycle chains
// the next frame with no idle gap.
module uart_byte_tx #(
  parameter int DIV = 215
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int CW = $clog2(DIV + 2);
  localparam logic [CW-1:0] DIVC = CW'(DIV);

  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [9:0]    sh;

  assign done = active && (cnt == '0) && (idx == 4'd9);
  assign txd  = active ? sh[0] : 1'b1;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      active <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '1;
    end else if (start && (!active || done)) begin
      active <= 1'b1;
      cnt    <= DIVC;
      idx    <= '0;
      sh     <= {1'b1, data, 1'b0};
    end else if (active) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (idx == 4'd9) begin
        active <= 1'b0;
      end else begin
        cnt <= DIVC;
        idx <= idx + 1'b1;
        sh  <= {1'b1, sh[9:1]};
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Serial debug bridge: 8N1 command bytes in, single 32-bit bus
// cycles out, acknowledge or read data returned on txd.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int DIV          = 215,
  parameter int BUS_TIMEOUT  = 255,
  parameter int IDLE_TIMEOUT = 20
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        rxd,
  output logic        txd,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic        busy_o
);

  localparam int CW  = $clog2(DIV + 2);
  localparam int ITO = IDLE_TIMEOUT * (DIV + 1);
  localparam int IW  = $clog2(ITO + 1);
  localparam int BW  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] DIVC = CW'(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic rx_m, rx_s, rx_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  rxstate_t      rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_valid;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_valid = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        if (rx_q && !rx_s) begin
          rx_st_n  = RX_START;
          rx_cnt_n = HALF;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else if (!rx_s) begin
          rx_st_n  = RX_DATA;
          rx_cnt_n = DIVC;
          rx_bit_n = '0;
        end else begin
          rx_st_n = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else begin
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_cnt_n = DIVC;
          rx_bit_n = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else begin
          rx_valid = rx_s;
          rx_st_n  = RX_IDLE;
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  pstate_t       st, st_n;
  logic [1:0]    bcnt;
  logic          cmd_we;
  logic [31:0]   adr_q, dat_q, rdata;
  logic [IW-1:0] ito;
  logic [BW-1:0] bto;
  rkind_t        rkind;
  logic [1:0]    ridx, rlast, tx_idx;
  logic          first;
  logic          tx_start, tx_done;
  logic [7:0]    tx_data;
  logic          ito_hit, bto_hit;

  assign ito_hit = (ito == IW'(ITO - 1));
  assign bto_hit = (bto == BW'(BUS_TIMEOUT - 1));
  assign busy_o  = (st != P_IDLE);

  always_comb begin
    st_n = st;
    unique case (st)
      P_IDLE: begin
        if (rx_valid) begin
          if (rx_sh == CMD_WR || rx_sh == CMD_RD) st_n = P_ADDR;
          else st_n = P_REPLY;
        end
      end
      P_ADDR: begin
        if (rx_valid) begin
          if (bcnt == 2'd3) st_n = cmd_we ? P_DATA : P_BUS;
        end else if (ito_hit) begin
          st_n = P_IDLE;
        end
      end
      P_DATA: begin
        if (rx_valid) begin
          if (bcnt == 2'd3) st_n = P_BUS;
        end else if (ito_hit) begin
          st_n = P_IDLE;
        end
      end
      P_BUS: begin
        if (ack_i || bto_hit) st_n = P_REPLY;
      end
      P_REPLY: begin
        if (tx_done && ridx == rlast) st_n = P_IDLE;
      end
      default: st_n = P_IDLE;
    endcase
  end

  // First reply byte is kicked on entry; the rest chain on tx_done.
  always_comb begin
    tx_idx   = first ? 2'd0 : ridx + 2'd1;
    tx_start = (st == P_REPLY) &&
               (first || (tx_done && ridx != rlast));
    tx_data  = RSP_ERR;
    unique case (rkind)
      RP_OK:  tx_data = RSP_OK;
      RP_ERR: tx_data = RSP_ERR;
      RP_TO:  tx_data = RSP_TO;
      RP_RD: begin
        unique case (tx_idx)
          2'd0: tx_data = rdata[31:24];
          2'd1: tx_data = rdata[23:16];
          2'd2: tx_data = rdata[15:8];
          2'd3: tx_data = rdata[7:0];
          default: tx_data = rdata[7:0];
        endcase
      end
      default: tx_data = RSP_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      st     <= P_IDLE;
      bcnt   <= '0;
      cmd_we <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdata  <= '0;
      ito    <= '0;
      bto    <= '0;
      rkind  <= RP_ERR;
      ridx   <= '0;
      rlast  <= '0;
      first  <= 1'b0;
      adr_o  <= '0;
      dat_o  <= '0;
      sel_o  <= '0;
      we_o   <= 1'b0;
      stb_o  <= 1'b0;
    end else begin
      st    <= st_n;
      first <= (st != P_REPLY) && (st_n == P_REPLY);
      if (rx_valid && st == P_IDLE) begin
        cmd_we <= (rx_sh == CMD_WR);
        bcnt   <= '0;
        rkind  <= RP_ERR;
        rlast  <= '0;
      end
      if (rx_valid && (st == P_ADDR || st == P_DATA))
        bcnt <= bcnt + 1'b1;
      if (rx_valid && st == P_ADDR)
        adr_q <= {adr_q[23:0], rx_sh};
      if (rx_valid && st == P_DATA)
        dat_q <= {dat_q[23:0], rx_sh};
      if (rx_valid || st_n != st)
        ito <= '0;
      else if (st == P_ADDR || st == P_DATA)
        ito <= ito + 1'b1;
      if (st != P_BUS && st_n == P_BUS) begin
        adr_o <= (st == P_ADDR) ? {adr_q[23:0], rx_sh} : adr_q;
        dat_o <= (st == P_DATA) ? {dat_q[23:0], rx_sh} : dat_q;
        we_o  <= cmd_we;
        sel_o <= 4'hF;
        stb_o <= 1'b1;
        bto   <= '0;
      end
      if (st == P_BUS) begin
        bto <= bto + 1'b1;
        if (st_n != P_BUS) begin
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          sel_o <= 4'h0;
          if (ack_i) begin
            rdata <= dat_i;
            rkind <= we_o ? RP_OK : RP_RD;
            rlast <= we_o ? 2'd0 : 2'd3;
          end else begin
            rkind <= RP_TO;
            rlast <= 2'd0;
          end
        end
      end
      if (st != P_REPLY && st_n == P_REPLY)
        ridx <= '0;
      else if (st == P_REPLY && tx_done)
        ridx <= ridx + 1'b1;
    end
  end

  uart_byte_tx #(
    .DIV(DIV)
  ) u_tx (
    .clk   (clk),
    .rst_ni(rst_ni),
    .start (tx_start),
    .data  (tx_data),
    .txd   (txd),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with DIV=7 (8 clk per bit).
module tb_uart_bus_master;

  localparam int DIV = 7;
  localparam int BP  = DIV + 1;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        we_o, stb_o, ack_i, busy_o;
  logic [31:0] dat_i = 32'h12345678;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int scnt = 0;
  int cyc = 0;

  int          npulse = 0;
  int          cur_w = 0;
  int          last_w = 0;
  int          ack_cyc = 0;
  logic        stb_prev = 1'b0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  logic [7:0] rxq[$];
  int         starts[$];

  uart_bus_master #(
    .DIV(DIV),
    .BUS_TIMEOUT(255),
    .IDLE_TIMEOUT(20)
  ) dut (
    .clk   (clk),
    .rst_ni(rst_ni),
    .rxd   (rxd),
    .txd   (txd),
    .adr_o (adr_o),
    .dat_o (dat_o),
    .sel_o (sel_o),
    .we_o  (we_o),
    .stb_o (stb_o),
    .ack_i (ack_i),
    .dat_i (dat_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    scnt <= stb_o ? scnt + 1 : 0;
  end

  assign ack_i = stb_o && (mode == 1 || (mode == 2 && scnt == 3));

  always @(negedge clk) begin
    if (stb_o && !stb_prev) begin
      npulse  = npulse + 1;
      cur_w   = 1;
      cap_adr = adr_o;
      cap_dat = dat_o;
      cap_we  = we_o;
      cap_sel = sel_o;
    end else if (stb_o) begin
      cur_w = cur_w + 1;
    end
    if (!stb_o && stb_prev) last_w = cur_w;
    if (stb_o && ack_i) ack_cyc = cyc;
    stb_prev = stb_o;
  end

  initial begin : txmon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        starts.push_back(cyc);
        repeat (BP / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BP) @(negedge clk);
          b[i] = txd;
        end
        repeat (BP) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = f[i];
      repeat (BP - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_bytes(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic clear_mon();
    rxq.delete();
    starts.delete();
  endtask

  task automatic wait_reply(input int n, input string name);
    int i;
    i = 0;
    while (i < 3000 && !(rxq.size() >= n && !busy_o)) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (i >= 3000) begin
      failures++;
      $display("FAIL %s_wait: got %0d bytes busy=%b, need %0d idle",
               name, rxq.size(), busy_o, n);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      failures++; $display("FAIL rst_txd: got %b want 1", txd);
    end
    checks++;
    if (stb_o !== 1'b0 || we_o !== 1'b0) begin
      failures++; $display("FAIL rst_stb_we: got %b%b want 00", stb_o, we_o);
    end
    checks++;
    if (sel_o !== 4'h0) begin
      failures++; $display("FAIL rst_sel: got %h want 0", sel_o);
    end
    checks++;
    if (adr_o !== 32'h0 || dat_o !== 32'h0) begin
      failures++; $display("FAIL rst_adr_dat: got %h %h want 0", adr_o, dat_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL rst_busy: got %b want 0", busy_o);
    end
    rst_ni = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (rxq.size() != 0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_quiet: got %0d bytes busy=%b want 0", rxq.size(), busy_o);
    end
  endtask

  task automatic test_write();
    int p0;
    clear_mon();
    p0 = npulse;
    mode = 2;
    send_bytes(72'h57_0000000C_DEADBEEF, 9);
    wait_reply(1, "wr");
    checks++;
    if (npulse - p0 != 1) begin
      failures++; $display("FAIL wr_pulses: got %0d want 1", npulse - p0);
    end
    checks++;
    if (cap_adr !== 32'h0000000C || cap_dat !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_adr_dat: got %h %h want 0000000c deadbeef", cap_adr, cap_dat);
    end
    checks++;
    if (cap_we !== 1'b1 || cap_sel !== 4'hF) begin
      failures++; $display("FAIL wr_we_sel: got %b %h want 1 f", cap_we, cap_sel);
    end
    checks++;
    if (last_w != 4) begin
      failures++; $display("FAIL wr_stb_width: got %0d want 4", last_w);
    end
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h4B) begin
      failures++;
      $display("FAIL wr_reply: got %0d bytes first %h want 1 byte 4b",
               rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
    end
    checks++;
    if (starts.size() < 1 || starts[0] - ack_cyc < 1 || starts[0] - ack_cyc > 2) begin
      failures++;
      $display("FAIL wr_ack_to_tx: got %0d want 1..2",
               starts.size() > 0 ? starts[0] - ack_cyc : -1);
    end
  endtask

  task automatic test_read();
    int p0;
    clear_mon();
    p0 = npulse;
    mode = 1;
    send_bytes(72'h52_00000004, 5);
    wait_reply(4, "rd");
    checks++;
    if (npulse - p0 != 1 || last_w != 1) begin
      failures++;
      $display("FAIL rd_stb: got pulses %0d width %0d want 1 1", npulse - p0, last_w);
    end
    checks++;
    if (cap_adr !== 32'h4 || cap_we !== 1'b0) begin
      failures++; $display("FAIL rd_adr_we: got %h %b want 00000004 0", cap_adr, cap_we);
    end
    checks++;
    if (rxq.size() != 4 || {rxq[0], rxq[1], rxq[2], rxq[3]} !== 32'h12345678) begin
      failures++;
      $display("FAIL rd_reply: got %0d bytes want 12 34 56 78", rxq.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (starts.size() < 4 || starts[k+1] - starts[k] != 10 * BP) begin
        failures++;
        $display("FAIL rd_gap%0d: got %0d want %0d", k,
                 starts.size() > k + 1 ? starts[k+1] - starts[k] : -1, 10 * BP);
      end
    end
  endtask

  task automatic test_timeout();
    int p0;
    clear_mon();
    p0 = npulse;
    mode = 0;
    send_bytes(72'h52_00000100, 5);
    wait_reply(1, "to");
    checks++;
    if (npulse - p0 != 1 || last_w != 255) begin
      failures++;
      $display("FAIL to_stb: got pulses %0d width %0d want 1 255", npulse - p0, last_w);
    end
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h54) begin
      failures++;
      $display("FAIL to_reply: got %0d bytes first %h want 1 byte 54",
               rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
    end
  endtask

  task automatic test_bad_cmd();
    int p0;
    clear_mon();
    p0 = npulse;
    send_byte(8'hA5);
    wait_reply(1, "bad");
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h3F) begin
      failures++;
      $display("FAIL bad_reply: got %0d bytes first %h want 1 byte 3f",
               rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
    end
    checks++;
    if (npulse != p0) begin
      failures++; $display("FAIL bad_stb: got %0d pulses want 0", npulse - p0);
    end
  endtask

  task automatic test_idle_timeout();
    int p0;
    clear_mon();
    p0 = npulse;
    send_bytes(72'h57_0000, 3);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++; $display("FAIL ito_busy_mid: got %b want 1", busy_o);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || rxq.size() != 0 || npulse != p0) begin
      failures++;
      $display("FAIL ito_drop: got busy %b bytes %0d pulses %0d want 0 0 0",
               busy_o, rxq.size(), npulse - p0);
    end
    mode = 1;
    send_bytes(72'h52_00000008, 5);
    wait_reply(4, "ito");
    checks++;
    if (npulse - p0 != 1 || cap_adr !== 32'h8) begin
      failures++;
      $display("FAIL ito_next_adr: got %0d pulses adr %h want 1 00000008",
               npulse - p0, cap_adr);
    end
    checks++;
    if (rxq.size() != 4 || {rxq[0], rxq[1], rxq[2], rxq[3]} !== 32'h12345678) begin
      failures++; $display("FAIL ito_next_reply: got %0d bytes want 12345678", rxq.size());
    end
  endtask

  task automatic test_glitch();
    int p0;
    clear_mon();
    p0 = npulse;
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL glitch_busy: got %b want 0", busy_o);
    end
    send_byte(8'h52, 1'b0);
    repeat (200) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || rxq.size() != 0 || npulse != p0) begin
      failures++;
      $display("FAIL frame_err: got busy %b bytes %0d pulses %0d want 0 0 0",
               busy_o, rxq.size(), npulse - p0);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    clear_mon();
    mode = 1;
    send_bytes(72'h52_00000004, 5);
    i = 0;
    while (i < 1000 && starts.size() < 2) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (i >= 1000) begin
      failures++; $display("FAIL rm_reply_start: got %0d starts want 2", starts.size());
    end
    repeat (12) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rm_reply_rst: got txd %b busy %b want 1 0", txd, busy_o);
    end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    mode = 0;
    send_bytes(72'h52_00000010, 5);
    i = 0;
    while (i < 100 && !stb_o) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (stb_o !== 1'b1) begin
      failures++; $display("FAIL rm_stb_rise: got %b want 1", stb_o);
    end
    repeat (5) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (stb_o !== 1'b0 || txd !== 1'b1 || sel_o !== 4'h0) begin
      failures++;
      $display("FAIL rm_bus_rst: got stb %b txd %b sel %h want 0 1 0", stb_o, txd, sel_o);
    end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (100) @(negedge clk);
    clear_mon();
    repeat (300) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || rxq.size() != 0) begin
      failures++;
      $display("FAIL rm_no_reply: got busy %b bytes %0d want 0 0", busy_o, rxq.size());
    end
    mode = 2;
    send_bytes(72'h57_00000020_11223344, 9);
    wait_reply(1, "rm");
    checks++;
    if (cap_adr !== 32'h20 || cap_dat !== 32'h11223344 || rxq.size() != 1 ||
        rxq[0] !== 8'h4B) begin
      failures++;
      $display("FAIL rm_fresh: got adr %h dat %h bytes %0d want 00000020 11223344 1",
               cap_adr, cap_dat, rxq.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_bad_cmd();
    test_idle_timeout();
    test_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
